csr_file_m: RTL and testbench
=============================

Name: csr_file_m

Overview:
Parametrised machine-mode CSR file for the rvcpu core. Supersedes the fixed 64-bit CSR file and adds:
- XLEN selection with high-half counters.
- Set/clear CSR ops and WARL field masking.
- An minstret counter.
- External and software interrupt sources beside the timer, with fixed-priority arbitration.
- Vectored mtvec.
- Atomic trap-entry and mret sequencing, replacing the separate per-CSR clint write ports.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64
HART_ID, 0, value returned by mhartid
RESET_MTVEC, 0, mtvec reset value (bits [1:0] forced per WARL)
VECTORED_EN, 1, 1 enables mtvec mode 1; 0 forces mtvec[1:0]=00

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_en_i  in  1  CSR instruction valid this cycle
csr_op_i  in  2  01 RW, 10 RS, 11 RC, 00 read-only access
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  rs1 or zimm operand
csr_rdata_o  out  XLEN  read data (pre-write value)
csr_illegal_o  out  1  access is illegal; no state change
instret_i  in  1  one instruction retired
trap_req_i  in  1  trap entry (exception or taken interrupt)
trap_cause_i  in  XLEN  mcause value; MSB set = interrupt
trap_pc_i  in  XLEN  pc saved into mepc
trap_tval_i  in  XLEN  mtval value
mret_i  in  1  mret executed
irq_timer_i, irq_soft_i, irq_ext_i  in  1 each  level interrupt lines
irq_req_o  out  1  an enabled interrupt is pending and global MIE=1
irq_cause_o  out  XLEN  mcause for the highest-priority pending interrupt
trap_vector_o  out  XLEN  redirect pc for the current trap_cause_i
mepc_o  out  XLEN  mepc for mret redirect

Behaviour:
- Reset, asynchronous on rst_n low:
  - mstatus: MPP=11, MIE=0, MPIE=0.
  - mie, mepc, mcause, mtval, mscratch, mcycle, minstret and the irq sample flops all 0.
  - mtvec = RESET_MTVEC.
- Outputs held at reset: irq_req_o=0, irq_cause_o=0, csr_illegal_o=0.
- Implemented addresses:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
  - mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
  - XLEN=32 only: mcycleh 0xB80 and minstreth 0xB82, both writable.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata.
  - A write occurs when csr_en_i=1, op!=00 and the access is not illegal.
  - RS/RC with wdata=0 still count as a write; the value is unchanged.
- WARL masking:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 11; all other bits read 0.
  - mie and mip: only bits 3, 7 and 11 are defined; others read 0.
  - mepc[0] reads 0. mtvec[1] reads 0. mtvec[0] reads 0 when VECTORED_EN=0.
- mip is read-only and reflects the sampled irq lines: MSIP[3]=irq_soft_i, MTIP[7]=irq_timer_i, MEIP[11]=irq_ext_i.
  - Each line is registered once, giving 1-cycle latency.
  - Writes to mip are ignored and are not illegal.
- csr_illegal_o is combinational and asserts when csr_en_i=1 and either:
  - the address is unimplemented, or
  - the address has bits [11:10]=11 and op!=00.
- csr_rdata_o is combinational and returns the current (pre-write) value; unimplemented addresses read 0.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instret_i=1.
  - A CSR write to either counter (either half when XLEN=32) loads the written value that cycle instead of incrementing.
  - Counters are 64-bit and wrap from all-ones to 0.
- Interrupt arbitration, combinational from the registered mip/mie/mstatus:
  - pend = mip & mie. irq_req_o = mstatus.MIE & |pend.
  - Priority ext > soft > timer; irq_cause_o = {1, code} with code 11, 3 or 7.
- Trap entry, on the clock edge with trap_req_i=1:
  - mepc = trap_pc_i with bit 0 cleared; mcause = trap_cause_i; mtval = trap_tval_i.
  - MPIE = MIE, MIE = 0, MPP = 11.
- mret: MIE = MPIE, MPIE = 1.
- Same-cycle priority: trap_req_i > mret_i > CSR write.
  - A losing CSR write is dropped entirely, including any counter load.
  - Counter increments still occur in that cycle.
- trap_vector_o:
  - Base = mtvec with bits [1:0] cleared.
  - If mtvec mode = 01 and trap_cause_i MSB = 1: base + 4*trap_cause_i[XLEN-2:0]; otherwise base.
- mepc_o = mepc.

Test Plan:
- Reset mid-run: counters at 0x55 with mie=0x888; assert rst_n low asynchronously (no clock edge) -> mcycle=0, mie=0, mstatus reads 0x1800, mtvec=RESET_MTVEC immediately.
- CSR ops: RW mscratch=0xF0, RS 0x0F, RC 0x30 -> rdata returns pre-write values 0xF0 then 0xFF; final value 0xCF. Write 0xFFFF to mstatus -> reads 0x1888.
- Illegal: write to 0xF14 or access 0x7C0 -> csr_illegal_o=1, no state change; read 0xF14 -> HART_ID, illegal=0.
- Interrupt priority: mie=0x888, MIE=1, all three lines high -> after 1 cycle irq_req_o=1, irq_cause_o={1,11}. Drop ext -> cause {1,3}. MIE=0 -> irq_req_o=0.
- Trap/mret and vectoring:
  - Setup: mtvec=0x8000_0001, MIE=1; trap_req_i with cause {1,7}, pc 0x1003, simultaneous csrrw to mscratch.
  - Trap response: trap_vector_o=0x8000_001C; mepc=0x1002; MIE=0, MPIE=1; mscratch unchanged.
  - Then mret_i -> MIE=1, MPIE=1.
- Counters at XLEN=32: write mcycleh=0xFFFF_FFFF, mcycle=0xFFFF_FFFE -> wraps to 0 two cycles later. With instret_i held high, minstret gains exactly the number of asserted cycles.

Source files
------------

// File: rtl/csr_file_m_if.sv
// CSR access, trap sequencing and interrupt signalling between the core and csr_file_m.
// The master side is the core pipeline; the slave side is the CSR file.
interface csr_file_m_if #(
    parameter int unsigned XLEN = 64
);
    logic            csr_en_i;
    logic [1:0]      csr_op_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_illegal_o;
    logic            instret_i;
    logic            trap_req_i;
    logic [XLEN-1:0] trap_cause_i;
    logic [XLEN-1:0] trap_pc_i;
    logic [XLEN-1:0] trap_tval_i;
    logic            mret_i;
    logic            irq_timer_i;
    logic            irq_soft_i;
    logic            irq_ext_i;
    logic            irq_req_o;
    logic [XLEN-1:0] irq_cause_o;
    logic [XLEN-1:0] trap_vector_o;
    logic [XLEN-1:0] mepc_o;

    modport master (
        output csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i, instret_i,
        output trap_req_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_i,
        output irq_timer_i, irq_soft_i, irq_ext_i,
        input  csr_rdata_o, csr_illegal_o, irq_req_o, irq_cause_o, trap_vector_o, mepc_o
    );

    modport slave (
        input  csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i, instret_i,
        input  trap_req_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_i,
        input  irq_timer_i, irq_soft_i, irq_ext_i,
        output csr_rdata_o, csr_illegal_o, irq_req_o, irq_cause_o, trap_vector_o, mepc_o
    );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: WARL-masked CSRs, 64-bit cycle/instret counters, fixed-priority
// interrupt arbitration and atomic trap-entry / mret sequencing.
module csr_file_m #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter bit              VECTORED_EN = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    csr_file_m_if.slave bus
);
    localparam bit Is32 = (XLEN == 32);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMie       = 12'h304;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMscratch  = 12'h340;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMtval     = 12'h343;
    localparam logic [11:0] AddrMip       = 12'h344;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;
    localparam logic [11:0] AddrMhartid   = 12'hF14;

    localparam logic [XLEN-1:0] MtvecMask = {{(XLEN-2){1'b1}}, 1'b0, VECTORED_EN};
    localparam logic [XLEN-1:0] MepcMask  = {{(XLEN-1){1'b1}}, 1'b0};

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;   // {MEIE, MTIE, MSIE}
    logic [2:0]      mip_q;          // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wval;
    logic [63:0]     wval64;
    logic            implemented;
    logic            illegal;
    logic            csr_write;
    logic [2:0]      pend;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_offset;

    // Read mux; rdata is also the "old" value for RS/RC.
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (bus.csr_addr_i)
            AddrMstatus: begin
                rdata[12:11] = 2'b11;
                rdata[7]     = mstatus_mpie_q;
                rdata[3]     = mstatus_mie_q;
            end
            AddrMie: begin
                rdata[11] = mie_q[2];
                rdata[7]  = mie_q[1];
                rdata[3]  = mie_q[0];
            end
            AddrMip: begin
                rdata[11] = mip_q[2];
                rdata[7]  = mip_q[1];
                rdata[3]  = mip_q[0];
            end
            AddrMtvec:    rdata = mtvec_q;
            AddrMscratch: rdata = mscratch_q;
            AddrMepc:     rdata = mepc_q;
            AddrMcause:   rdata = mcause_q;
            AddrMtval:    rdata = mtval_q;
            AddrMcycle:   rdata = XLEN'(mcycle_q);
            AddrMinstret: rdata = XLEN'(minstret_q);
            AddrMcycleh: begin
                if (Is32) rdata = XLEN'(mcycle_q[63:32]);
                else      implemented = 1'b0;
            end
            AddrMinstreth: begin
                if (Is32) rdata = XLEN'(minstret_q[63:32]);
                else      implemented = 1'b0;
            end
            AddrMhartid:  rdata = HART_ID;
            default:      implemented = 1'b0;
        endcase
    end

    always_comb begin
        wval = rdata;
        unique case (bus.csr_op_i)
            2'b01:   wval = bus.csr_wdata_i;
            2'b10:   wval = rdata | bus.csr_wdata_i;
            2'b11:   wval = rdata & ~bus.csr_wdata_i;
            default: wval = rdata;
        endcase
    end

    assign wval64 = 64'(wval);

    // The 0xC00-0xFFF range is read-only; any write attempt there is illegal.
    assign illegal = bus.csr_en_i & (~implemented |
                     ((bus.csr_addr_i[11:10] == 2'b11) & (bus.csr_op_i != 2'b00)));

    assign csr_write = bus.csr_en_i & (bus.csr_op_i != 2'b00) & ~illegal &
                       ~bus.trap_req_i & ~bus.mret_i;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + 64'(bus.instret_i);

        if (bus.trap_req_i) begin
            mepc_d         = bus.trap_pc_i & MepcMask;
            mcause_d       = bus.trap_cause_i;
            mtval_d        = bus.trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (bus.mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_write) begin
            case (bus.csr_addr_i)
                AddrMstatus: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                AddrMie:      mie_d      = {wval[11], wval[7], wval[3]};
                AddrMtvec:    mtvec_d    = wval & MtvecMask;
                AddrMscratch: mscratch_d = wval;
                AddrMepc:     mepc_d     = wval & MepcMask;
                AddrMcause:   mcause_d   = wval;
                AddrMtval:    mtval_d    = wval;
                // A counter load replaces the increment for the whole 64-bit counter.
                AddrMcycle:   mcycle_d   = Is32 ? {mcycle_q[63:32], wval64[31:0]} : wval64;
                AddrMinstret: minstret_d = Is32 ? {minstret_q[63:32], wval64[31:0]} : wval64;
                AddrMcycleh: begin
                    if (Is32) mcycle_d = {wval64[31:0], mcycle_q[31:0]};
                end
                AddrMinstreth: begin
                    if (Is32) minstret_d = {wval64[31:0], minstret_q[31:0]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= RESET_MTVEC & MtvecMask;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= {bus.irq_ext_i, bus.irq_timer_i, bus.irq_soft_i};
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    // Fixed priority: external > software > timer.
    always_comb begin
        pend     = mip_q & mie_q;
        irq_code = 4'd0;
        if (pend[2])      irq_code = 4'd11;
        else if (pend[0]) irq_code = 4'd3;
        else if (pend[1]) irq_code = 4'd7;
        irq_cause = '0;
        if (pend != 3'b000) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[3:0]    = irq_code;
        end
    end

    always_comb begin
        vec_base   = {mtvec_q[XLEN-1:2], 2'b00};
        vec_offset = {bus.trap_cause_i[XLEN-3:0], 2'b00};
    end

    assign bus.csr_rdata_o   = rdata;
    assign bus.csr_illegal_o = illegal & rst_n;
    assign bus.irq_req_o     = mstatus_mie_q & (pend != 3'b000);
    assign bus.irq_cause_o   = irq_cause;
    assign bus.trap_vector_o = ((mtvec_q[1:0] == 2'b01) && bus.trap_cause_i[XLEN-1]) ?
                               vec_base + vec_offset : vec_base;
    assign bus.mepc_o        = mepc_q;
endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m (XLEN=32): directed scenarios plus a randomized run
// checked against an architectural model of the CSR state.
module tb_csr_file_m;
    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] HART      = 32'h0000_002A;
    localparam logic [31:0] RST_MTVEC = 32'h0000_0100;
    localparam logic [1:0]  RO = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    csr_file_m_if #(.XLEN(XLEN)) bus ();

    csr_file_m #(
        .XLEN        (XLEN),
        .HART_ID     (HART),
        .RESET_MTVEC (RST_MTVEC),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Architectural model: mstatus keeps only MIE/MPIE, mip holds last cycle's lines.
    logic [31:0] m_status, m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;

    function automatic void m_reset();
        m_status = 0; m_ie = 0; m_ip = 0; m_tvec = RST_MTVEC;
        m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | m_status;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal(input logic [1:0] op, input logic [11:0] a);
        bit impl;
        impl = a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14};
        return !impl || (a >= 12'hC00 && op != RO);
    endfunction

    function automatic logic [31:0] m_next(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] wd);
        if (op == RW) return wd;
        if (op == RS) return old | wd;
        if (op == RC) return old & ~wd;
        return old;
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: m_status  = v & 32'h88;
            12'h304: m_ie      = v & 32'h888;
            12'h305: m_tvec    = v & 32'hFFFF_FFFD;
            12'h340: m_scratch = v;
            12'h341: m_epc     = v & 32'hFFFF_FFFE;
            12'h342: m_cause   = v;
            12'h343: m_tval    = v;
            default: ;
        endcase
    endfunction

    function automatic void m_trap(input logic [31:0] c, input logic [31:0] p,
                                   input logic [31:0] t);
        m_epc = p & 32'hFFFF_FFFE; m_cause = c; m_tval = t;
        m_status = m_status[3] ? 32'h80 : 32'h0;
    endfunction

    function automatic void m_mret();
        m_status = m_status[7] ? 32'h88 : 32'h80;
    endfunction

    function automatic logic [31:0] m_vector(input logic [31:0] c);
        logic [31:0] base;
        base = m_tvec & 32'hFFFF_FFFC;
        if (m_tvec[1:0] == 2'b01 && c[31]) return base + 32'd4 * (c & 32'h7FFF_FFFF);
        return base;
    endfunction

    function automatic logic [31:0] m_irq_cause();
        logic [31:0] p;
        p = m_ip & m_ie;
        if (p[11]) return 32'h8000_000B;
        if (p[3])  return 32'h8000_0003;
        if (p[7])  return 32'h8000_0007;
        return 32'h0;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        bus.csr_en_i = 1'b1; bus.csr_op_i = op; bus.csr_addr_i = a; bus.csr_wdata_i = wd;
    endtask

    task automatic idle_bus();
        bus.csr_en_i = 1'b0; bus.csr_op_i = RO; bus.trap_req_i = 1'b0; bus.mret_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(RW, 12'h304, 32'h888); tick();
        drive(RW, 12'hB00, 32'h55); tick();
        drive(RW, 12'hB02, 32'h55); tick();
        idle_bus(); bus.csr_addr_i = 12'h304; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h888) begin miscompares++;
            $display("FAIL pre_reset_mie: got %h want %h", bus.csr_rdata_o, 32'h888); end
        #1 rst_n = 1'b0;
        bus.csr_addr_i = 12'hB00; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL rst_mcycle: got %h want 0", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'hB02; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL rst_minstret: got %h want 0", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'h304; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL rst_mie: got %h want 0", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'h300; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h1800) begin miscompares++;
            $display("FAIL rst_mstatus: got %h want %h", bus.csr_rdata_o, 32'h1800); end
        bus.csr_addr_i = 12'h305; #1;
        vectors++; if (bus.csr_rdata_o !== RST_MTVEC) begin miscompares++;
            $display("FAIL rst_mtvec: got %h want %h", bus.csr_rdata_o, RST_MTVEC); end
        drive(RW, 12'h7C0, 32'h1); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b0 || bus.irq_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_outputs: got ill=%b req=%b want 0 0",
                     bus.csr_illegal_o, bus.irq_req_o); end
        idle_bus();
        @(negedge clk); rst_n = 1'b1; m_reset(); tick();
    endtask

    task automatic test_csr_ops();
        drive(RW, 12'h340, 32'hF0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL rw_pre: got %h want 0", bus.csr_rdata_o); end
        tick(); drive(RS, 12'h340, 32'h0F); #1;
        vectors++; if (bus.csr_rdata_o !== 32'hF0) begin miscompares++;
            $display("FAIL rs_pre: got %h want %h", bus.csr_rdata_o, 32'hF0); end
        tick(); drive(RC, 12'h340, 32'h30); #1;
        vectors++; if (bus.csr_rdata_o !== 32'hFF) begin miscompares++;
            $display("FAIL rc_pre: got %h want %h", bus.csr_rdata_o, 32'hFF); end
        tick(); drive(RS, 12'h340, 32'h0); tick(); drive(RO, 12'h340, 32'h0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'hCF) begin miscompares++;
            $display("FAIL ops_final: got %h want %h", bus.csr_rdata_o, 32'hCF); end
        tick(); drive(RW, 12'h300, 32'hFFFF); tick(); drive(RO, 12'h300, 32'h0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'h1888) begin miscompares++;
            $display("FAIL mstatus_warl: got %h want %h", bus.csr_rdata_o, 32'h1888); end
        tick(); drive(RW, 12'h304, 32'hFFFF_FFFF); tick(); drive(RO, 12'h304, 32'h0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'h888) begin miscompares++;
            $display("FAIL mie_warl: got %h want %h", bus.csr_rdata_o, 32'h888); end
        tick(); drive(RW, 12'h341, 32'h1235); tick(); drive(RO, 12'h341, 32'h0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'h1234) begin miscompares++;
            $display("FAIL mepc_warl: got %h want %h", bus.csr_rdata_o, 32'h1234); end
        tick(); drive(RW, 12'h305, 32'hFFFF_FFFF); tick(); drive(RW, 12'h344, 32'hFFF); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b0) begin miscompares++;
            $display("FAIL mip_write_legal: got %b want 0", bus.csr_illegal_o); end
        tick(); drive(RW, 12'h305, RST_MTVEC); #1;
        vectors++; if (bus.csr_rdata_o !== 32'hFFFF_FFFD) begin miscompares++;
            $display("FAIL mtvec_warl: got %h want %h", bus.csr_rdata_o, 32'hFFFF_FFFD); end
        tick(); drive(RO, 12'h344, 32'h0); #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL mip_ro: got %h want 0", bus.csr_rdata_o); end
        tick(); idle_bus();
        m_scratch = 32'hCF; m_status = 32'h88; m_ie = 32'h888; m_epc = 32'h1234;
        m_tvec = RST_MTVEC;
    endtask

    task automatic test_illegal();
        drive(RW, 12'hF14, 32'h1234); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b1) begin miscompares++;
            $display("FAIL ill_hartid_wr: got %b want 1", bus.csr_illegal_o); end
        tick(); drive(RO, 12'hF14, 32'h0); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b0 || bus.csr_rdata_o !== HART) begin
            miscompares++;
            $display("FAIL hartid_rd: got ill=%b %h want 0 %h",
                     bus.csr_illegal_o, bus.csr_rdata_o, HART); end
        tick(); drive(RS, 12'h7C0, 32'hFF); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b1 || bus.csr_rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL ill_unimpl: got ill=%b %h want 1 0",
                     bus.csr_illegal_o, bus.csr_rdata_o); end
        tick(); drive(RO, 12'h7C0, 32'h0); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b1) begin miscompares++;
            $display("FAIL ill_unimpl_rd: got %b want 1", bus.csr_illegal_o); end
        tick(); idle_bus(); #1;
        vectors++; if (bus.csr_illegal_o !== 1'b0) begin miscompares++;
            $display("FAIL ill_no_en: got %b want 0", bus.csr_illegal_o); end
        tick();
    endtask

    task automatic test_irq();
        drive(RW, 12'h304, 32'h888); tick(); drive(RW, 12'h300, 32'h8); tick(); idle_bus();
        bus.irq_ext_i = 1'b1; bus.irq_timer_i = 1'b1; bus.irq_soft_i = 1'b1; #1;
        vectors++; if (bus.irq_req_o !== 1'b0) begin miscompares++;
            $display("FAIL irq_latency: got %b want 0", bus.irq_req_o); end
        tick(); bus.csr_addr_i = 12'h344; #1;
        vectors++; if (bus.irq_req_o !== 1'b1 || bus.irq_cause_o !== 32'h8000_000B) begin
            miscompares++;
            $display("FAIL irq_ext: got %b %h want 1 8000000b", bus.irq_req_o, bus.irq_cause_o);
        end
        vectors++; if (bus.csr_rdata_o !== 32'h888) begin miscompares++;
            $display("FAIL mip_all: got %h want %h", bus.csr_rdata_o, 32'h888); end
        bus.irq_ext_i = 1'b0; tick();
        vectors++; if (bus.irq_cause_o !== 32'h8000_0003) begin miscompares++;
            $display("FAIL irq_soft: got %h want 80000003", bus.irq_cause_o); end
        bus.irq_soft_i = 1'b0; tick();
        vectors++; if (bus.irq_cause_o !== 32'h8000_0007) begin miscompares++;
            $display("FAIL irq_timer: got %h want 80000007", bus.irq_cause_o); end
        drive(RW, 12'h300, 32'h0); tick(); idle_bus(); #1;
        vectors++; if (bus.irq_req_o !== 1'b0) begin miscompares++;
            $display("FAIL irq_gmie_off: got %b want 0", bus.irq_req_o); end
        bus.irq_timer_i = 1'b0; tick();
        m_status = 0; m_ie = 32'h888; m_ip = 0;
    endtask

    task automatic test_trap();
        drive(RW, 12'h305, 32'h8000_0001); tick(); drive(RW, 12'h300, 32'h8); tick();
        drive(RW, 12'h340, 32'hDEAD);
        bus.trap_req_i = 1'b1; bus.trap_cause_i = 32'h8000_0007;
        bus.trap_pc_i = 32'h1003; bus.trap_tval_i = 32'hBAD; #1;
        vectors++; if (bus.trap_vector_o !== 32'h8000_001C) begin miscompares++;
            $display("FAIL vec_irq: got %h want 8000001c", bus.trap_vector_o); end
        tick(); idle_bus(); bus.csr_addr_i = 12'h300; #1;
        vectors++; if (bus.mepc_o !== 32'h1002) begin miscompares++;
            $display("FAIL trap_mepc: got %h want 1002", bus.mepc_o); end
        vectors++; if (bus.csr_rdata_o !== 32'h1880) begin miscompares++;
            $display("FAIL trap_mstatus: got %h want 1880", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'h340; #1;
        vectors++; if (bus.csr_rdata_o !== 32'hCF) begin miscompares++;
            $display("FAIL trap_drops_wr: got %h want cf", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'h342; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h8000_0007) begin miscompares++;
            $display("FAIL trap_mcause: got %h want 80000007", bus.csr_rdata_o); end
        bus.trap_cause_i = 32'h2; #1;
        vectors++; if (bus.trap_vector_o !== 32'h8000_0000) begin miscompares++;
            $display("FAIL vec_exc: got %h want 80000000", bus.trap_vector_o); end
        drive(RW, 12'h300, 32'h0); bus.mret_i = 1'b1; tick(); idle_bus();
        bus.csr_addr_i = 12'h300; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h1888) begin miscompares++;
            $display("FAIL mret_mstatus: got %h want 1888", bus.csr_rdata_o); end
        tick();
        m_tvec = 32'h8000_0001; m_status = 32'h88; m_epc = 32'h1002;
        m_cause = 32'h8000_0007; m_tval = 32'hBAD;
    endtask

    task automatic test_counters();
        logic [31:0] v;
        int n;
        drive(RW, 12'hB80, 32'hFFFF_FFFF); tick(); drive(RW, 12'hB00, 32'hFFFF_FFFE); tick();
        idle_bus(); bus.csr_addr_i = 12'hB00; #1;
        vectors++; if (bus.csr_rdata_o !== 32'hFFFF_FFFE) begin miscompares++;
            $display("FAIL cyc_load: got %h want fffffffe", bus.csr_rdata_o); end
        tick(); tick(); bus.csr_addr_i = 12'hB80; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL cyc_wrap_hi: got %h want 0", bus.csr_rdata_o); end
        bus.csr_addr_i = 12'hB00; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL cyc_wrap_lo: got %h want 0", bus.csr_rdata_o); end
        tick(); bus.csr_addr_i = 12'hB00; #1; v = bus.csr_rdata_o;
        drive(RW, 12'hB00, 32'h1000); bus.trap_req_i = 1'b1; bus.trap_cause_i = 32'h5;
        bus.trap_pc_i = 32'h40; bus.trap_tval_i = 32'h0; tick(); idle_bus();
        m_trap(32'h5, 32'h40, 32'h0); bus.csr_addr_i = 12'hB00; #1;
        vectors++; if (bus.csr_rdata_o !== v + 32'd1) begin miscompares++;
            $display("FAIL cyc_dropped_load: got %h want %h", bus.csr_rdata_o, v + 32'd1); end
        tick(); drive(RW, 12'hB02, 32'h0); tick(); drive(RW, 12'hB82, 32'h0); tick(); idle_bus();
        n = $urandom_range(5, 40);
        bus.instret_i = 1'b1; repeat (n) tick(); bus.instret_i = 1'b0;
        bus.csr_addr_i = 12'hB02; #1;
        vectors++; if (bus.csr_rdata_o !== 32'(n)) begin miscompares++;
            $display("FAIL instret_count: got %h want %h", bus.csr_rdata_o, 32'(n)); end
        tick(); bus.instret_i = 1'b1; drive(RW, 12'hB02, 32'h100); tick(); idle_bus();
        bus.instret_i = 1'b0; bus.csr_addr_i = 12'hB02; #1;
        vectors++; if (bus.csr_rdata_o !== 32'h100) begin miscompares++;
            $display("FAIL instret_load: got %h want 100", bus.csr_rdata_o); end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hF14, 12'h7C0, 12'hC00, 12'h301};
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            logic [1:0]  op;
            logic [31:0] wd, cause, pc, tval;
            logic [2:0]  lines;
            bit          trap, mret, ill;
            a     = addrs[$urandom_range(0, 11)];
            op    = 2'($urandom_range(0, 3));
            wd    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            trap  = ($urandom_range(0, 7) == 0);
            mret  = !trap && ($urandom_range(0, 7) == 0);
            cause = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
            pc    = $urandom; tval = $urandom; lines = 3'($urandom);
            drive(op, a, wd);
            bus.trap_req_i = trap; bus.mret_i = mret; bus.trap_cause_i = cause;
            bus.trap_pc_i = pc; bus.trap_tval_i = tval;
            bus.irq_ext_i = lines[2]; bus.irq_timer_i = lines[1]; bus.irq_soft_i = lines[0];
            #1;
            ill = m_illegal(op, a);
            vectors++; if (bus.csr_rdata_o !== m_read(a) || bus.csr_illegal_o !== ill) begin
                miscompares++;
                $display("FAIL rand_rd[%0d] a=%h: got %h ill=%b want %h ill=%b", i, a,
                         bus.csr_rdata_o, bus.csr_illegal_o, m_read(a), ill); end
            vectors++; if (bus.irq_req_o !== (m_status[3] && (m_ip & m_ie) != 0) ||
                           bus.irq_cause_o !== m_irq_cause()) begin
                miscompares++;
                $display("FAIL rand_irq[%0d]: got %b %h want cause %h", i, bus.irq_req_o,
                         bus.irq_cause_o, m_irq_cause()); end
            vectors++; if (bus.trap_vector_o !== m_vector(cause) || bus.mepc_o !== m_epc) begin
                miscompares++;
                $display("FAIL rand_vec[%0d]: got %h %h want %h %h", i, bus.trap_vector_o,
                         bus.mepc_o, m_vector(cause), m_epc); end
            tick();
            if (trap)                  m_trap(cause, pc, tval);
            else if (mret)             m_mret();
            else if (op != RO && !ill) m_write(a, m_next(op, m_read(a), wd));
            m_ip = (32'(lines[2]) << 11) | (32'(lines[1]) << 7) | (32'(lines[0]) << 3);
        end
        idle_bus();
        bus.irq_ext_i = 1'b0; bus.irq_timer_i = 1'b0; bus.irq_soft_i = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        bus.csr_en_i = 1'b0; bus.csr_op_i = RO; bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
        bus.instret_i = 1'b0; bus.trap_req_i = 1'b0; bus.trap_cause_i = '0;
        bus.trap_pc_i = '0; bus.trap_tval_i = '0; bus.mret_i = 1'b0;
        bus.irq_timer_i = 1'b0; bus.irq_soft_i = 1'b0; bus.irq_ext_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_reset();
        tick();
        test_reset();
        test_csr_ops();
        test_illegal();
        test_irq();
        test_trap();
        test_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
